// File: rtl/pcam_fault_collector.sv
// Pivot-CAM fault collector: turns the BIST fault stream into pivot entries with
// per-entry row/column hit counters and must-repair flags, failing on PCAM overflow.
module pcam_fault_collector #(
    parameter int PCAM   = 8,
    parameter int ADDR_W = 10,
    parameter int SR     = 2,
    parameter int SC     = 2,
    parameter int CNT_W  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         bist_done,
    input  logic                         fault_valid,
    input  logic [ADDR_W-1:0]            fault_row,
    input  logic [ADDR_W-1:0]            fault_col,
    output logic                         fault_ready,
    output logic [PCAM*ADDR_W-1:0]       pcam_row,
    output logic [PCAM*ADDR_W-1:0]       pcam_col,
    output logic [PCAM-1:0]              pcam_vld,
    output logic [PCAM-1:0]              must_row,
    output logic [PCAM-1:0]              must_col,
    output logic [$clog2(PCAM+1)-1:0]    pivot_cnt,
    output logic                         busy,
    output logic                         done,
    output logic                         fail
);

    localparam int PC_W = $clog2(PCAM+1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;
    localparam logic [1:0] S_FAIL    = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] ROW_TH  = CNT_W'(SC);
    localparam logic [CNT_W-1:0] COL_TH  = CNT_W'(SR);

    logic [1:0]        state;
    logic [ADDR_W-1:0] row_q   [PCAM];
    logic [ADDR_W-1:0] col_q   [PCAM];
    logic [CNT_W-1:0]  row_cnt [PCAM];
    logic [CNT_W-1:0]  col_cnt [PCAM];
    logic [PCAM-1:0]   vld_q;

    logic [PCAM-1:0]   rmatch;
    logic [PCAM-1:0]   cmatch;
    logic [PCAM-1:0]   free_oh;
    logic              accept;
    logic              exact;
    logic              non_pivot;
    logic              new_pivot;
    logic              overflow;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        rmatch = '0;
        cmatch = '0;
        for (int i = 0; i < PCAM; i++) begin
            rmatch[i] = vld_q[i] && (row_q[i] == fault_row);
            cmatch[i] = vld_q[i] && (col_q[i] == fault_col);
        end
    end

    // Lowest clear bit of the valid vector, one-hot; zero when the PCAM is full.
    assign free_oh   = ~vld_q & (vld_q + PCAM'(1));
    assign accept    = fault_valid && (state == S_COLLECT);
    assign exact     = |(rmatch & cmatch);
    assign non_pivot = accept && !exact && ((|rmatch) || (|cmatch));
    assign new_pivot = accept && !(|rmatch) && !(|cmatch);
    assign overflow  = new_pivot && !(|free_oh);

    // NOTE: the entry array is reset along with the control state so no stale pivot survives rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            vld_q <= '0;
            for (int i = 0; i < PCAM; i++) begin
                row_q[i]   <= '0;
                col_q[i]   <= '0;
                row_cnt[i] <= '0;
                col_cnt[i] <= '0;
            end
        end else if (start) begin
            state <= S_COLLECT;
            vld_q <= '0;
            for (int i = 0; i < PCAM; i++) begin
                row_q[i]   <= '0;
                col_q[i]   <= '0;
                row_cnt[i] <= '0;
                col_cnt[i] <= '0;
            end
        end else if (state == S_COLLECT) begin
            // NOTE: sequential state is updated with <= so all entries see the pre-edge match vectors.
            for (int i = 0; i < PCAM; i++) begin
                if (non_pivot && rmatch[i] && (row_cnt[i] != CNT_MAX))
                    row_cnt[i] <= row_cnt[i] + CNT_ONE;
                if (non_pivot && cmatch[i] && (col_cnt[i] != CNT_MAX))
                    col_cnt[i] <= col_cnt[i] + CNT_ONE;
                if (new_pivot && free_oh[i]) begin
                    row_q[i]   <= fault_row;
                    col_q[i]   <= fault_col;
                    vld_q[i]   <= 1'b1;
                    row_cnt[i] <= '0;
                    col_cnt[i] <= '0;
                end
            end
            if (overflow)
                state <= S_FAIL;
            else if (bist_done)
                state <= S_DONE;
        end
    end

    always_comb begin
        pivot_cnt = '0;
        must_row  = '0;
        must_col  = '0;
        pcam_row  = '0;
        pcam_col  = '0;
        for (int i = 0; i < PCAM; i++) begin
            pivot_cnt                   = pivot_cnt + PC_W'(vld_q[i]);
            must_row[i]                 = vld_q[i] && (row_cnt[i] >= ROW_TH);
            must_col[i]                 = vld_q[i] && (col_cnt[i] >= COL_TH);
            pcam_row[i*ADDR_W +: ADDR_W] = row_q[i];
            pcam_col[i*ADDR_W +: ADDR_W] = col_q[i];
        end
    end

    assign pcam_vld    = vld_q;
    assign busy        = (state == S_COLLECT);
    assign fault_ready = busy;
    assign done        = (state == S_DONE);
    assign fail        = (state == S_FAIL);

endmodule

// File: tb/tb_pcam_fault_collector.sv
// Scoreboard bench for pcam_fault_collector: a behavioural PCAM model pushes the
// expected post-edge view per driven cycle; it is popped and compared after the edge.
module tb_pcam_fault_collector;

    localparam int PCAM   = 8;
    localparam int ADDR_W = 10;
    localparam int SR     = 2;
    localparam int SC     = 2;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic                      clk = 1'b0;
    logic                      rst = 1'b0;
    logic                      start = 1'b0;
    logic                      bist_done = 1'b0;
    logic                      fault_valid = 1'b0;
    logic [ADDR_W-1:0]         fault_row = '0;
    logic [ADDR_W-1:0]         fault_col = '0;
    logic                      fault_ready;
    logic [PCAM*ADDR_W-1:0]    pcam_row;
    logic [PCAM*ADDR_W-1:0]    pcam_col;
    logic [PCAM-1:0]           pcam_vld;
    logic [PCAM-1:0]           must_row;
    logic [PCAM-1:0]           must_col;
    logic [$clog2(PCAM+1)-1:0] pivot_cnt;
    logic                      busy;
    logic                      done;
    logic                      fail;

    pcam_fault_collector #(
        .PCAM(PCAM), .ADDR_W(ADDR_W), .SR(SR), .SC(SC), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .bist_done(bist_done),
        .fault_valid(fault_valid), .fault_row(fault_row), .fault_col(fault_col),
        .fault_ready(fault_ready), .pcam_row(pcam_row), .pcam_col(pcam_col),
        .pcam_vld(pcam_vld), .must_row(must_row), .must_col(must_col),
        .pivot_cnt(pivot_cnt), .busy(busy), .done(done), .fail(fail)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PCAM*ADDR_W-1:0] row;
        logic [PCAM*ADDR_W-1:0] col;
        logic [PCAM-1:0]        vld;
        logic [PCAM-1:0]        mr;
        logic [PCAM-1:0]        mc;
        int                     pc;
        logic                   busy;
        logic                   done;
        logic                   fail;
    } snap_t;

    snap_t exp_q[$];

    // Reference model: 0 idle, 1 collect, 2 done, 3 fail
    int                m_state;
    logic [ADDR_W-1:0] m_row [PCAM];
    logic [ADDR_W-1:0] m_col [PCAM];
    logic              m_vld [PCAM];
    int                m_rc  [PCAM];
    int                m_cc  [PCAM];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_clear(input int st);
        m_state = st;
        for (int i = 0; i < PCAM; i++) begin
            m_row[i] = '0; m_col[i] = '0; m_vld[i] = 1'b0; m_rc[i] = 0; m_cc[i] = 0;
        end
    endtask

    task automatic model_step(input logic fv, input logic [ADDR_W-1:0] r,
                              input logic [ADDR_W-1:0] c, input logic bd, input logic st);
        bit any_r, any_c, dup, ovf;
        int cnt, slot;
        if (st) begin
            model_clear(1);
            return;
        end
        if (m_state != 1) return;
        ovf = 0;
        if (fv) begin
            any_r = 0; any_c = 0; dup = 0; cnt = 0; slot = -1;
            for (int i = 0; i < PCAM; i++) begin
                if (m_vld[i]) begin
                    cnt++;
                    if (m_row[i] == r) any_r = 1;
                    if (m_col[i] == c) any_c = 1;
                    if (m_row[i] == r && m_col[i] == c) dup = 1;
                end else if (slot < 0) begin
                    slot = i;
                end
            end
            if (!dup && (any_r || any_c)) begin
                for (int i = 0; i < PCAM; i++) begin
                    if (m_vld[i] && m_row[i] == r && m_rc[i] < CMAX) m_rc[i]++;
                    if (m_vld[i] && m_col[i] == c && m_cc[i] < CMAX) m_cc[i]++;
                end
            end else if (!dup) begin
                if (cnt == PCAM) ovf = 1;
                else begin
                    m_row[slot] = r; m_col[slot] = c; m_vld[slot] = 1'b1;
                    m_rc[slot] = 0; m_cc[slot] = 0;
                end
            end
        end
        if (ovf) m_state = 3;
        else if (bd) m_state = 2;
    endtask

    function automatic snap_t model_snap();
        snap_t s;
        s.row = '0; s.col = '0; s.vld = '0; s.mr = '0; s.mc = '0; s.pc = 0;
        for (int i = 0; i < PCAM; i++) begin
            s.row[i*ADDR_W +: ADDR_W] = m_row[i];
            s.col[i*ADDR_W +: ADDR_W] = m_col[i];
            s.vld[i] = m_vld[i];
            s.mr[i]  = m_vld[i] && (m_rc[i] >= SC);
            s.mc[i]  = m_vld[i] && (m_cc[i] >= SR);
            if (m_vld[i]) s.pc++;
        end
        s.busy = (m_state == 1);
        s.done = (m_state == 2);
        s.fail = (m_state == 3);
        return s;
    endfunction

    task automatic compare_pop(input string tag);
        snap_t e;
        if (exp_q.size() == 0) begin
            check({tag, ".queue_empty"}, 1, 0);
            return;
        end
        e = exp_q.pop_front();
        check({tag, ".pcam_vld"},  pcam_vld,  e.vld);
        check({tag, ".pivot_cnt"}, pivot_cnt, e.pc);
        check({tag, ".pcam_row"},  pcam_row,  e.row);
        check({tag, ".pcam_col"},  pcam_col,  e.col);
        check({tag, ".must_row"},  must_row,  e.mr);
        check({tag, ".must_col"},  must_col,  e.mc);
        check({tag, ".busy"},      busy,      e.busy);
        check({tag, ".ready"},     fault_ready, e.busy);
        check({tag, ".done"},      done,      e.done);
        check({tag, ".fail"},      fail,      e.fail);
    endtask

    // Drives one cycle of stimulus, enqueues its expected result, compares after the edge.
    task automatic cycle(input string tag, input logic fv, input int r, input int c,
                         input logic bd, input logic st);
        start       = st;
        bist_done   = bd;
        fault_valid = fv;
        fault_row   = ADDR_W'(r);
        fault_col   = ADDR_W'(c);
        model_step(fv, ADDR_W'(r), ADDR_W'(c), bd, st);
        exp_q.push_back(model_snap());
        @(posedge clk);
        #1;
        start = 1'b0; bist_done = 1'b0; fault_valid = 1'b0;
        compare_pop(tag);
    endtask

    task automatic fault(input string tag, input int r, input int c);
        cycle(tag, 1'b1, r, c, 1'b0, 1'b0);
    endtask

    task automatic do_start(input string tag);
        cycle(tag, 1'b0, 0, 0, 1'b0, 1'b1);
    endtask

    initial begin
        model_clear(0);
        rst = 1'b1;
        #12;
        exp_q.push_back(model_snap());
        compare_pop("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Distinct pivots, then exact duplicates leave everything unchanged
        do_start("t1.start");
        fault("t1.f57", 5, 7);
        fault("t1.f93", 9, 3);
        fault("t1.dup", 5, 7);
        fault("t1.dup2", 5, 7);

        // Shared row drives must_row
        do_start("t2.start");
        fault("t2.f57", 5, 7);
        fault("t2.f52", 5, 2);
        fault("t2.f54", 5, 4);

        // Row and column hits on two different entries in one fault
        do_start("t3.start");
        fault("t3.f57", 5, 7);
        fault("t3.f93", 9, 3);
        fault("t3.f97", 9, 7);
        fault("t3.f47", 4, 7);

        // Saturation of a row counter keeps must_row asserted
        do_start("t4.start");
        fault("t4.piv", 2, 2);
        for (int i = 0; i < 20; i++) fault("t4.sat", 2, 100 + i);

        // Overflow: ninth distinct pivot fails, fault_ready drops, entries frozen
        do_start("t5.start");
        for (int i = 0; i < 9; i++) fault("t5.fill", 10 + i, 40 + i);
        fault("t5.ignored", 300, 301);
        cycle("t5.bd_in_fail", 1'b0, 0, 0, 1'b1, 1'b0);

        // Fault together with bist_done, then restart
        do_start("t6.start");
        cycle("t6.f11_bd", 1'b1, 1, 1, 1'b1, 1'b0);
        fault("t6.after_done", 2, 2);
        do_start("t6.restart");

        // start with a fault in the same cycle: fault dropped, entries cleared
        fault("t7.f33", 3, 3);
        cycle("t7.start_fault", 1'b1, 6, 6, 1'b0, 1'b1);
        // start beats bist_done
        cycle("t7.start_bd", 1'b0, 0, 0, 1'b1, 1'b1);

        // Asynchronous reset between edges
        fault("t8.f11", 1, 1);
        fault("t8.f22", 2, 2);
        #3;
        rst = 1'b1;
        #1;
        model_clear(0);
        exp_q.push_back(model_snap());
        compare_pop("t8.async_rst");
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        fault("t8.post_rst", 4, 4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
